// File: rtl/usr_pkg.sv
// Shared definitions for the burst shifter: mode codes, FSM states and a
// helper that tells which modes may run as a counted burst.
package usr_pkg;

    typedef logic [2:0] mode_t;

    localparam mode_t MODE_HOLD  = 3'b000;
    localparam mode_t MODE_SHU   = 3'b001;
    localparam mode_t MODE_SHD   = 3'b010;
    localparam mode_t MODE_LOAD  = 3'b011;
    localparam mode_t MODE_ROTU  = 3'b100;
    localparam mode_t MODE_ROTD  = 3'b101;
    localparam mode_t MODE_ASHD  = 3'b110;
    localparam mode_t MODE_CLR   = 3'b111;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Hold, load and clear give the same result on every repeat, so they never burst.
    function automatic logic is_burst_mode(input mode_t m);
        return (m == MODE_SHU) || (m == MODE_SHD) || (m == MODE_ROTU) ||
               (m == MODE_ROTD) || (m == MODE_ASHD);
    endfunction

endpackage

// File: rtl/usr_burst_shifter_if.sv
// Control/data bundle between a sequencer (master) and the burst shifter (slave).
interface usr_burst_shifter_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic [2:0]       mode;
    logic [WIDTH-1:0] pdata_in;
    logic             sin_lsb;
    logic             sin_msb;
    logic             start;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] q;
    logic             sout_lsb;
    logic             sout_msb;
    logic             busy;
    logic             done;

    modport master (
        output mode, pdata_in, sin_lsb, sin_msb, start, count,
        input  q, sout_lsb, sout_msb, busy, done
    );

    modport slave (
        input  mode, pdata_in, sin_lsb, sin_msb, start, count,
        output q, sout_lsb, sout_msb, busy, done
    );
endinterface

// File: rtl/usr_next_val.sv
// Combinational next-value function of the universal shift register.
module usr_next_val
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  mode_t            i_mode,
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_sin_lsb,
    input  logic             i_sin_msb,
    input  logic [WIDTH-1:0] i_pdata,
    output logic [WIDTH-1:0] o_q_next
);

    always_comb begin
        o_q_next = i_q;
        case (i_mode)
            MODE_HOLD: o_q_next = i_q;
            MODE_SHU:  o_q_next = {i_q[WIDTH-2:0], i_sin_lsb};
            MODE_SHD:  o_q_next = {i_sin_msb, i_q[WIDTH-1:1]};
            MODE_LOAD: o_q_next = i_pdata;
            MODE_ROTU: o_q_next = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
            MODE_ROTD: o_q_next = {i_q[0], i_q[WIDTH-1:1]};
            MODE_ASHD: o_q_next = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
            MODE_CLR:  o_q_next = '0;
            default:   o_q_next = i_q;
        endcase
    end

endmodule

// File: rtl/usr_burst_shifter.sv
// Universal shift register with a counted burst engine: one start command
// runs up to 2^CNT_W-1 steps of a latched mode, reported via busy/done.
module usr_burst_shifter
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic                clk,
    input  logic                clr,
    usr_burst_shifter_if.slave  bus
);

    state_t           r_state;
    mode_t            r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_q;
    logic             r_busy;
    logic             r_done;

    mode_t            w_mode_sel;
    logic [WIDTH-1:0] w_q_next;
    logic             w_burst_start;

    // While running, the live mode input is ignored in favour of the latched one.
    assign w_mode_sel    = (r_state == ST_RUN) ? r_mode : bus.mode;
    assign w_burst_start = bus.start && is_burst_mode(bus.mode) && (bus.count != '0);

    usr_next_val #(
        .WIDTH (WIDTH)
    ) u_next_val (
        .i_mode    (w_mode_sel),
        .i_q       (r_q),
        .i_sin_lsb (bus.sin_lsb),
        .i_sin_msb (bus.sin_msb),
        .i_pdata   (bus.pdata_in),
        .o_q_next  (w_q_next)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_HOLD;
            r_cnt   <= '0;
            r_q     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_burst_start) begin
                        r_mode  <= bus.mode;
                        r_cnt   <= bus.count;
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_q <= w_q_next;
                        // Degenerate start: one step, then report completion.
                        if (bus.start) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_q   <= w_q_next;
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.q        = r_q;
    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.sout_lsb = r_q[0];
    assign bus.sout_msb = r_q[WIDTH-1];

endmodule

// File: tb/tb_usr_burst_shifter.sv
// Directed plus randomized checks of usr_burst_shifter against an arithmetic reference model.
module tb_usr_burst_shifter;

    logic clk = 1'b0;
    logic clr = 1'b0;
    int   n_cmp = 0;
    int   n_mis = 0;
    int   exp_q = 0;

    always #5 clk = ~clk;

    usr_burst_shifter_if #(.WIDTH(8), .CNT_W(4)) bus ();

    usr_burst_shifter #(.WIDTH(8), .CNT_W(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    // Reference step on an 8-bit value using plain integer arithmetic.
    function automatic int ref_step(int m, int v, int sl, int sm, int pd);
        case (m)
            0:       return v;
            1:       return (v * 2 + sl) % 256;
            2:       return v / 2 + sm * 128;
            3:       return pd % 256;
            4:       return (v * 2) % 256 + v / 128;
            5:       return v / 2 + (v % 2) * 128;
            6:       return v / 2 + (v / 128) * 128;
            default: return 0;
        endcase
    endfunction

    task automatic chk(string tag, int obs, int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all(string tag, int e_busy, int e_done);
        chk({tag, ".q"}, int'(bus.q), exp_q);
        chk({tag, ".busy"}, int'(bus.busy), e_busy);
        chk({tag, ".done"}, int'(bus.done), e_done);
        chk({tag, ".sout_lsb"}, int'(bus.sout_lsb), exp_q % 2);
        chk({tag, ".sout_msb"}, int'(bus.sout_msb), exp_q / 128);
        $display("step %-10s q=%02h busy=%0d done=%0d", tag, bus.q, bus.busy, bus.done);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Single idle step with start low.
    task automatic idle_step(string tag, int m, int pd, int sl, int sm);
        bus.mode = 3'(m); bus.pdata_in = 8'(pd);
        bus.sin_lsb = 1'(sl); bus.sin_msb = 1'(sm); bus.start = 1'b0;
        exp_q = ref_step(m, exp_q, sl, sm, pd);
        tick;
        chk_all(tag, 0, 0);
    endtask

    // Counted burst; inputs other than sin_* are scrambled while running.
    task automatic burst(string tag, int m, int c, bit chain);
        bus.mode = 3'(m); bus.count = 4'(c); bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        chk_all({tag, ".lat"}, 1, 0);
        for (int i = 1; i <= c; i++) begin
            int sl, sm;
            sl = int'($urandom_range(0, 1));
            sm = int'($urandom_range(0, 1));
            bus.mode = 3'($urandom_range(0, 7));
            bus.count = 4'($urandom_range(0, 15));
            bus.start = 1'($urandom_range(0, 1));
            bus.pdata_in = 8'($urandom);
            bus.sin_lsb = 1'(sl); bus.sin_msb = 1'(sm);
            exp_q = ref_step(m, exp_q, sl, sm, 0);
            tick;
            chk_all($sformatf("%s.%0d", tag, i), (i < c) ? 1 : 0, (i == c) ? 1 : 0);
        end
        bus.start = 1'b0;
        bus.mode = 3'd0;
        if (!chain) begin
            tick;
            chk_all({tag, ".end"}, 0, 0);
        end
    endtask

    initial begin
        int burst_modes[5] = '{1, 2, 4, 5, 6};
        bus.mode = 3'd0; bus.pdata_in = 8'd0; bus.sin_lsb = 1'b0; bus.sin_msb = 1'b0;
        bus.start = 1'b0; bus.count = 4'd0;

        // Asynchronous reset between edges
        tick;
        bus.mode = 3'd3; bus.pdata_in = 8'h5A;
        tick;
        #2 clr = 1'b1;
        #1;
        exp_q = 0;
        chk_all("reset", 0, 0);
        bus.mode = 3'd0;
        tick;
        clr = 1'b0;
        chk_all("reset2", 0, 0);

        // Idle single steps
        idle_step("load", 3, 'hA5, 0, 0);
        chk("load.lit", int'(bus.q), 'hA5);
        idle_step("shu", 1, 0, 1, 0);
        chk("shu.lit", int'(bus.q), 'h4B);
        idle_step("ashd", 6, 0, 0, 1);
        chk("ashd.lit", int'(bus.q), 'h25);

        // Rotate burst from 0x81
        idle_step("ld81", 3, 'h81, 0, 0);
        burst("rot", 4, 3, 1'b1);
        chk("rot.lit", int'(bus.q), 'h0C);
        tick;
        chk_all("rot.end", 0, 0);

        // Arithmetic burst from 0x90, then start again in the done cycle
        idle_step("ld90", 3, 'h90, 0, 0);
        burst("ash", 6, 4, 1'b1);
        chk("ash.lit", int'(bus.q), 'hF9);
        burst("b2b", 2, 2, 1'b0);

        // Degenerate starts
        idle_step("ld12", 3, 'h12, 0, 0);
        bus.mode = 3'd1; bus.count = 4'd0; bus.sin_lsb = 1'b0; bus.start = 1'b1;
        exp_q = ref_step(1, exp_q, 0, 0, 0);
        tick;
        bus.start = 1'b0; bus.mode = 3'd0;
        chk_all("cnt0", 0, 1);
        tick;
        chk_all("cnt0.end", 0, 0);
        bus.mode = 3'd7; bus.count = 4'd5; bus.start = 1'b1;
        exp_q = 0;
        tick;
        bus.start = 1'b0; bus.mode = 3'd0;
        chk_all("clrst", 0, 1);
        tick;
        chk_all("clrst.end", 0, 0);

        // Maximum count
        idle_step("ldmax", 3, 'h3C, 0, 0);
        burst("max", 5, 15, 1'b0);

        // Reset mid-burst
        idle_step("ldmid", 3, 'hE7, 0, 0);
        bus.mode = 3'd1; bus.count = 4'd15; bus.start = 1'b1;
        tick;
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) tick;
        chk("mid.busy", int'(bus.busy), 1);
        #2 clr = 1'b1;
        #1;
        exp_q = 0;
        chk_all("midclr", 0, 0);
        bus.start = 1'b1; bus.mode = 3'd1; bus.count = 4'd3;
        tick;
        bus.start = 1'b0; bus.mode = 3'd0;
        clr = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk_all($sformatf("postclr.%0d", i), 0, 0);
        end
        idle_step("ldpost", 3, 'h6D, 0, 0);
        burst("post", 2, 2, 1'b0);

        // Randomized idle steps and bursts
        for (int i = 0; i < 30; i++) begin
            idle_step($sformatf("rs%0d", i), int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                      int'($urandom_range(0, 1)), int'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 8; i++) begin
            idle_step($sformatf("rl%0d", i), 3, int'($urandom_range(1, 255)), 0, 0);
            burst($sformatf("rb%0d", i), burst_modes[$urandom_range(0, 4)],
                  int'($urandom_range(1, 15)), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
